// File: rtl/rect_drawer_pkg.sv
// ----------------------------------------------------------------------------
// rect_drawer_pkg
// Shared constants for the rectangle drawer and the pixel datapath it feeds:
// coordinate/colour widths, screen size, datapath opcodes, and a helper that
// packs one datapath instruction word.
//
// Instruction word layout (INSTRUCTION_WIDTH bits):
//   [3:0]   opcode
//   [11:4]  x coordinate
//   [18:12] y coordinate
//   [21:19] colour
//   [22]    draw flag (1 for DRAW, 0 for DISPLAY)
//   [23]    reserved, always 0
// ----------------------------------------------------------------------------
package rect_drawer_pkg;

    localparam int X_COORD_WIDTH     = 8;
    localparam int Y_COORD_WIDTH     = 7;
    localparam int COLOUR_WIDTH      = 3;
    localparam int OPCODE_WIDTH      = 4;
    localparam int INSTRUCTION_WIDTH = 24;

    localparam int SCREEN_WIDTH  = 160;
    localparam int SCREEN_HEIGHT = 120;

    localparam logic [OPCODE_WIDTH-1:0] OPCODE_NOP     = 4'h0;
    localparam logic [OPCODE_WIDTH-1:0] OPCODE_DRAW    = 4'h1;
    localparam logic [OPCODE_WIDTH-1:0] OPCODE_DISPLAY = 4'h2;

    // Packs one instruction word; the reserved top bit is always zero.
    function automatic logic [INSTRUCTION_WIDTH-1:0] make_instruction(
        input logic [OPCODE_WIDTH-1:0]  opcode,
        input logic [X_COORD_WIDTH-1:0] x,
        input logic [Y_COORD_WIDTH-1:0] y,
        input logic [COLOUR_WIDTH-1:0]  colour,
        input logic                     draw_flag
    );
        return {1'b0, draw_flag, colour, y, x, opcode};
    endfunction

endpackage

// File: rtl/rect_cursor.sv
// ----------------------------------------------------------------------------
// rect_cursor
// Holds the latched rectangle geometry and the row-major scan cursor.
// Reports whether the current cursor position lies on screen and whether it
// is the last pixel of the rectangle (regardless of clipping).
//
// Ports:
//   clock, resetn   rising-edge clock, synchronous active-low reset
//   load            latch rx/ry/rw/rh and place cursor at (rx,ry)
//   rewind          return cursor to the latched origin (second pass)
//   step            advance cursor one pixel in row-major order
//   rx, ry, rw, rh  rectangle origin and size (sampled on load)
//   cx, cy          current cursor position (valid when in_bounds=1)
//   in_bounds       cursor is inside SCREEN_WIDTH x SCREEN_HEIGHT
//   last            cursor is at the bottom-right pixel of the rectangle
// ----------------------------------------------------------------------------
module rect_cursor
    import rect_drawer_pkg::*;
(
    input  logic                     clock,
    input  logic                     resetn,
    input  logic                     load,
    input  logic                     rewind,
    input  logic                     step,
    input  logic [X_COORD_WIDTH-1:0] rx,
    input  logic [Y_COORD_WIDTH-1:0] ry,
    input  logic [7:0]               rw,
    input  logic [6:0]               rh,
    output logic [X_COORD_WIDTH-1:0] cx,
    output logic [Y_COORD_WIDTH-1:0] cy,
    output logic                     in_bounds,
    output logic                     last
);

    // One extra bit on each axis so origin+size never wraps; a cursor that
    // runs past the screen edge stays distinguishable from a small value.
    logic [X_COORD_WIDTH-1:0] x_org;
    logic [Y_COORD_WIDTH-1:0] y_org;
    logic [X_COORD_WIDTH:0]   x_end;
    logic [Y_COORD_WIDTH:0]   y_end;
    logic [X_COORD_WIDTH:0]   cur_x;
    logic [Y_COORD_WIDTH:0]   cur_y;

    logic row_last;
    logic col_last;

    always_comb begin
        row_last  = (cur_x + 9'd1) == x_end;
        col_last  = (cur_y + 8'd1) == y_end;
        last      = row_last && col_last;
        in_bounds = (cur_x < 9'(SCREEN_WIDTH)) && (cur_y < 8'(SCREEN_HEIGHT));
        cx        = cur_x[X_COORD_WIDTH-1:0];
        cy        = cur_y[Y_COORD_WIDTH-1:0];
    end

    // NOTE: state is updated with non-blocking assignments so every register
    // in this block sees the pre-edge values of the others.
    always_ff @(posedge clock) begin
        if (!resetn) begin
            x_org <= '0;
            y_org <= '0;
            x_end <= '0;
            y_end <= '0;
            cur_x <= '0;
            cur_y <= '0;
        end else if (load) begin
            x_org <= rx;
            y_org <= ry;
            x_end <= {1'b0, rx} + {1'b0, rw};
            y_end <= {1'b0, ry} + {1'b0, rh};
            cur_x <= {1'b0, rx};
            cur_y <= {1'b0, ry};
        end else if (rewind) begin
            cur_x <= {1'b0, x_org};
            cur_y <= {1'b0, y_org};
        end else if (step) begin
            if (row_last) begin
                cur_x <= {1'b0, x_org};
                cur_y <= cur_y + 8'd1;
            end else begin
                cur_x <= cur_x + 9'd1;
            end
        end
    end

endmodule

// File: rtl/rect_drawer.sv
// ----------------------------------------------------------------------------
// rect_drawer
// Fills a rectangle by issuing one datapath instruction per on-screen pixel.
// Off-screen pixels are skipped at one cursor step per cycle. Each pixel
// costs one ISSUE cycle plus the datapath round trip.
//
// Build option:
//   RECT_DRAWER_REFRESH_EN  when defined, a second pass re-visits the same
//                           on-screen pixels with OPCODE_DISPLAY before done.
//
// Ports:
//   clock, resetn   rising-edge clock, synchronous active-low reset
//   req             one-cycle request; accepted only when idle
//   rx, ry          top-left corner
//   rw, rh          width and height in pixels (zero -> immediate done)
//   rcolour         fill colour
//   instruction     datapath instruction, held between start pulses
//   start           one-cycle instruction-valid strobe
//   finished        datapath idle/complete flag
//   busy            high from request accept until the cycle after done
//   done            one-cycle completion pulse
// ----------------------------------------------------------------------------
module rect_drawer
    import rect_drawer_pkg::*;
(
    input  logic                         clock,
    input  logic                         resetn,
    input  logic                         req,
    input  logic [X_COORD_WIDTH-1:0]     rx,
    input  logic [Y_COORD_WIDTH-1:0]     ry,
    input  logic [7:0]                   rw,
    input  logic [6:0]                   rh,
    input  logic [COLOUR_WIDTH-1:0]      rcolour,
    output logic [INSTRUCTION_WIDTH-1:0] instruction,
    output logic                         start,
    input  logic                         finished,
    output logic                         busy,
    output logic                         done
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t                  state;
    state_t                  pass_next;
    logic [COLOUR_WIDTH-1:0] colour;

    logic                     load;
    logic                     rewind;
    logic                     step;
    logic                     pass_end;
    logic                     wait_over;
    logic [X_COORD_WIDTH-1:0] cx;
    logic [Y_COORD_WIDTH-1:0] cy;
    logic                     in_bounds;
    logic                     last;
    logic [INSTRUCTION_WIDTH-1:0] pixel_instruction;

`ifdef RECT_DRAWER_REFRESH_EN
    logic refresh_pass;
`endif

    rect_cursor u_cursor (
        .clock     (clock),
        .resetn    (resetn),
        .load      (load),
        .rewind    (rewind),
        .step      (step),
        .rx        (rx),
        .ry        (ry),
        .rw        (rw),
        .rh        (rh),
        .cx        (cx),
        .cy        (cy),
        .in_bounds (in_bounds),
        .last      (last)
    );

    // NOTE: every signal driven here gets a default first, so no path through
    // the block can leave one unassigned and infer a latch.
    always_comb begin
        load              = 1'b0;
        rewind            = 1'b0;
        step              = 1'b0;
        pass_end          = 1'b0;
        pass_next         = DONE;
        pixel_instruction = make_instruction(OPCODE_DRAW, cx, cy, colour, 1'b1);

        // start is high during the first WAIT cycle; finished is still the
        // pre-start value then, so it is not a completion.
        wait_over = (state == WAIT) && !start && finished;

        case (state)
            IDLE:  load = req;
            ISSUE: begin
                step     = !in_bounds && !last;
                pass_end = !in_bounds && last;
            end
            WAIT: begin
                step     = wait_over && !last;
                pass_end = wait_over && last;
            end
            default: ;
        endcase

`ifdef RECT_DRAWER_REFRESH_EN
        if (refresh_pass) begin
            pixel_instruction = make_instruction(OPCODE_DISPLAY, cx, cy, '0, 1'b0);
        end
        if (!refresh_pass) begin
            pass_next = ISSUE;
            rewind    = pass_end;
        end
`endif
    end

    always_ff @(posedge clock) begin
        if (!resetn) begin
            state       <= IDLE;
            start       <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            instruction <= '0;
            colour      <= '0;
`ifdef RECT_DRAWER_REFRESH_EN
            refresh_pass <= 1'b0;
`endif
        end else begin
            start <= 1'b0;
            done  <= 1'b0;

            case (state)
                IDLE: begin
                    if (req) begin
                        colour <= rcolour;
                        busy   <= 1'b1;
`ifdef RECT_DRAWER_REFRESH_EN
                        refresh_pass <= 1'b0;
`endif
                        state  <= (rw == 8'd0 || rh == 7'd0) ? DONE : ISSUE;
                    end else begin
                        busy <= 1'b0;
                    end
                end

                ISSUE: begin
                    if (in_bounds) begin
                        // Hold here until the datapath is ready.
                        if (finished) begin
                            start       <= 1'b1;
                            instruction <= pixel_instruction;
                            state       <= WAIT;
                        end
                    end else if (pass_end) begin
                        state <= pass_next;
`ifdef RECT_DRAWER_REFRESH_EN
                        refresh_pass <= 1'b1;
`endif
                    end
                end

                WAIT: begin
                    if (pass_end) begin
                        state <= pass_next;
`ifdef RECT_DRAWER_REFRESH_EN
                        refresh_pass <= 1'b1;
`endif
                    end else if (step) begin
                        state <= ISSUE;
                    end
                end

                DONE: begin
                    done  <= 1'b1;
                    state <= IDLE;
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_rect_drawer.sv
// ----------------------------------------------------------------------------
// tb_rect_drawer
// Directed bench for rect_drawer with a small datapath model: finished drops
// for three cycles after each start pulse, and can be held low by dp_stall.
// Every issued instruction is logged and compared against hand-computed
// words. Build with RECT_DRAWER_REFRESH_EN to expect the DISPLAY pass too.
// ----------------------------------------------------------------------------
module tb_rect_drawer;

    logic        clock = 1'b0;
    logic        resetn;
    logic        req;
    logic [7:0]  rx;
    logic [6:0]  ry;
    logic [7:0]  rw;
    logic [6:0]  rh;
    logic [2:0]  rcolour;
    logic [23:0] instruction;
    logic        start;
    logic        finished;
    logic        busy;
    logic        done;

    int total = 0;
    int bad   = 0;

    // Datapath model and observers
    logic        dp_stall  = 1'b0;
    int          dp_count  = 0;
    int          start_seen = 0;
    int          done_seen  = 0;
    int          bad_start  = 0;
    logic [23:0] log_q[$];
    logic [23:0] exp_q[$];

    always #5 clock = ~clock;

    assign finished = (dp_count == 0) && !dp_stall;

    rect_drawer dut (
        .clock       (clock),
        .resetn      (resetn),
        .req         (req),
        .rx          (rx),
        .ry          (ry),
        .rw          (rw),
        .rh          (rh),
        .rcolour     (rcolour),
        .instruction (instruction),
        .start       (start),
        .finished    (finished),
        .busy        (busy),
        .done        (done)
    );

    always @(negedge clock) begin
        if (start) begin
            if (!finished) bad_start++;
            log_q.push_back(instruction);
            start_seen++;
            dp_count <= 3;
        end else if (dp_count != 0) begin
            dp_count <= dp_count - 1;
        end
        if (done) done_seen++;
    end

    task automatic check(input string tag, input logic [31:0] observed,
                         input logic [31:0] expected);
        total++;
        assert (observed === expected) else begin
            bad++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    task automatic do_req(input logic [7:0] x, input logic [6:0] y,
                          input logic [7:0] w, input logic [6:0] h,
                          input logic [2:0] c);
        @(negedge clock);
        rx = x; ry = y; rw = w; rh = h; rcolour = c;
        req = 1'b1;
        @(negedge clock);
        req = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        int n = 0;
        while (done !== 1'b1 && n < 500) begin
            @(negedge clock);
            n++;
        end
        check({tag, "_done_in_time"}, 32'(n < 500), 32'd1);
    endtask

    // Appends the DISPLAY words expected after the DRAW words already queued.
    task automatic add_refresh_pass();
`ifdef RECT_DRAWER_REFRESH_EN
        int n = exp_q.size();
        for (int i = 0; i < n; i++) begin
            exp_q.push_back((exp_q[i] & 24'h07FFF0) | 24'h000002);
        end
`endif
    endtask

    task automatic check_log(input string tag);
        check({tag, "_count"}, 32'(log_q.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < log_q.size(); i++) begin
            check($sformatf("%s_ins%0d", tag, i), 32'(log_q[i]), 32'(exp_q[i]));
        end
        log_q.delete();
        exp_q.delete();
    endtask

    initial begin
        int d0;
        int s0;
        int n;

        resetn = 1'b0; req = 1'b0;
        rx = '0; ry = '0; rw = '0; rh = '0; rcolour = '0;
        repeat (3) @(negedge clock);
        check("rst_start", 32'(start), 32'd0);
        check("rst_busy",  32'(busy),  32'd0);
        check("rst_done",  32'(done),  32'd0);
        check("rst_instruction", 32'(instruction), 32'd0);
        resetn = 1'b1;
        @(negedge clock);

        // 2x2 at (10,5), colour 3; a second req while busy is ignored
        exp_q.push_back(24'h5850A1);
        exp_q.push_back(24'h5850B1);
        exp_q.push_back(24'h5860A1);
        exp_q.push_back(24'h5860B1);
        add_refresh_pass();
        d0 = done_seen;
        do_req(8'd10, 7'd5, 8'd2, 7'd2, 3'd3);
        check("rect_busy", 32'(busy), 32'd1);
        @(negedge clock);
        do_req(8'd50, 7'd50, 8'd1, 7'd1, 3'd7);
        wait_done("rect");
        @(negedge clock);
        check("rect_done_low", 32'(done), 32'd0);
        check("rect_busy_low", 32'(busy), 32'd0);
        check("rect_done_pulses", 32'(done_seen - d0), 32'd1);
        check_log("rect");

        // zero width: no start, done two cycles after req
        s0 = start_seen;
        do_req(8'd4, 7'd4, 8'd0, 7'd7, 3'd1);
        check("zero_busy", 32'(busy), 32'd1);
        check("zero_done_early", 32'(done), 32'd0);
        @(negedge clock);
        check("zero_done", 32'(done), 32'd1);
        @(negedge clock);
        check("zero_done_low", 32'(done), 32'd0);
        check("zero_busy_low", 32'(busy), 32'd0);
        check("zero_no_start", 32'(start_seen - s0), 32'd0);

        // clipping at the bottom-right corner
        exp_q.push_back(24'h6F79E1);
        exp_q.push_back(24'h6F79F1);
        add_refresh_pass();
        do_req(8'd158, 7'd119, 8'd4, 7'd3, 3'd5);
        wait_done("clip");
        @(negedge clock);
        check_log("clip");

        // datapath stalled for 20 cycles while ISSUE is pending
        exp_q.push_back(24'h49E141);
        add_refresh_pass();
        dp_stall = 1'b1;
        s0 = start_seen;
        do_req(8'd20, 7'd30, 8'd1, 7'd1, 3'd1);
        repeat (20) @(negedge clock);
        check("stall_no_start", 32'(start_seen - s0), 32'd0);
        check("stall_busy", 32'(busy), 32'd1);
        dp_stall = 1'b0;
        @(negedge clock);
        check("stall_start_first", 32'(start), 32'd1);
        wait_done("stall");
        @(negedge clock);
        check_log("stall");

        // reset after the second of four pixels, then a fresh request
        s0 = start_seen;
        n = 0;
        do_req(8'd10, 7'd5, 8'd2, 7'd2, 3'd3);
        while (start_seen - s0 < 2 && n < 300) begin
            @(negedge clock);
            n++;
        end
        check("abort_two_starts_in_time", 32'(n < 300), 32'd1);
        resetn = 1'b0;
        repeat (2) @(negedge clock);
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_start", 32'(start), 32'd0);
        check("abort_instruction", 32'(instruction), 32'd0);
        resetn = 1'b1;
        repeat (20) @(negedge clock);
        check("abort_no_more_starts", 32'(start_seen - s0), 32'd2);
        exp_q.push_back(24'h5850A1);
        exp_q.push_back(24'h5850B1);
        check_log("abort");
        exp_q.push_back(24'h504031);
        add_refresh_pass();
        do_req(8'd3, 7'd4, 8'd1, 7'd1, 3'd2);
        wait_done("after_abort");
        @(negedge clock);
        check_log("after_abort");

        // 1x1 at (0,0): DRAW, then DISPLAY when the refresh pass is built in
        exp_q.push_back(24'h780001);
        add_refresh_pass();
        do_req(8'd0, 7'd0, 8'd1, 7'd1, 3'd7);
        wait_done("origin");
        @(negedge clock);
        check_log("origin");

        check("start_only_when_finished", 32'(bad_start), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
